// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - framed serial-to-parallel receiver with FWFT output FIFO
// Optional even-parity bit compiled in with SERIAL_RX_PARITY_EN.
module serial_word_rx #(
  parameter int n     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sin,
  input  logic                       sin_en,
  output logic [n-1:0]               pout,
  output logic                       pvalid,
  input  logic                       pready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
    PARITY = 2'd2,
`endif
    STOP   = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [n-1:0]    shreg;
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic [AW:0]     wptr_n;
  logic [AW:0]     rptr_n;
  logic [n-1:0]    mem [DEPTH];
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            par_ok;
  logic            stop_strobe;

`ifdef SERIAL_RX_PARITY_EN
  logic            par_bit;
  assign par_ok = ~(^shreg ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  assign empty       = (wptr == rptr);
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop         = !empty && pready;
  assign stop_strobe = (state == STOP) && sin_en;
  // A full FIFO still takes the word when the consumer frees a slot on the same edge.
  assign push        = stop_strobe && sin && par_ok && (!full || pop);
  assign wptr_n      = wptr + (AW+1)'(push);
  assign rptr_n      = rptr + (AW+1)'(pop);

  assign pvalid = !empty;
  assign level  = wptr - rptr;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (sin_en) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= {sin, shreg[n-1:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(n-1)) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SERIAL_RX_PARITY_EN
          PARITY: begin
            par_bit <= sin;
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
            if (!sin)
              frame_err <= 1'b1;
            else if (!par_ok)
              parity_err <= 1'b1;
            else if (full && !pop)
              overrun <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= shreg;
  end

  // pout is the registered head; a word landing in the head slot is bypassed from shreg.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      pout <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      if (wptr_n != rptr_n) begin
        if (push && (rptr_n[AW-1:0] == wptr[AW-1:0]))
          pout <= shreg;
        else
          pout <= mem[rptr_n[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - directed self-checking bench for serial_word_rx
// Parity cases run when SERIAL_RX_PARITY_EN is defined.
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b1;
  logic       sin_en = 1'b0;
  logic       pready = 1'b0;
  logic [3:0] pout;
  logic       pvalid;
  logic [2:0] level;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;

  serial_word_rx #(.n(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
    .pout(pout), .pvalid(pvalid), .pready(pready), .level(level),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
  end

  task automatic clear_counts();
    fe_cnt = 0; pe_cnt = 0; ov_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; sin = 1'b1; sin_en = 1'b0; pready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One bit; sparse>0 inserts idle cycles with sin inverted before the strobe.
  task automatic strobe(input logic b, input int sparse);
    for (int k = 0; k < sparse; k++) begin
      sin = ~b; sin_en = 1'b0;
      @(posedge clk); #1;
    end
    sin = b; sin_en = 1'b1;
    @(posedge clk); #1;
    sin_en = 1'b0; sin = 1'b1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic par_flip, input logic stop,
                            input logic pop_on_stop, input int sparse);
    strobe(1'b0, sparse);
    for (int i = 0; i < 4; i++) strobe(d[i], sparse);
`ifdef SERIAL_RX_PARITY_EN
    strobe((^d) ^ par_flip, sparse);
`endif
    pready = pop_on_stop;
    strobe(stop, sparse);
    pready = 1'b0;
  endtask

  task automatic pop_one();
    pready = 1'b1;
    @(posedge clk); #1;
    pready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL reset_pvalid got=%b exp=0", pvalid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (pout !== 4'h0) begin errors++; $display("FAIL reset_pout got=%h exp=0", pout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses got=%b exp=000", {frame_err, parity_err, overrun}); end
  endtask

  task automatic test_single_frame();
    do_reset(); clear_counts();
    send_frame(4'hB, 1'b0, 1'b1, 1'b0, 0);
    checks++; if (pout !== 4'hB) begin errors++; $display("FAIL single_pout got=%h exp=b", pout); end
    checks++; if (pvalid !== 1'b1) begin errors++; $display("FAIL single_pvalid got=%b exp=1", pvalid); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (fe_cnt + pe_cnt + ov_cnt != 0) begin errors++;
      $display("FAIL single_no_err got=%0d exp=0", fe_cnt + pe_cnt + ov_cnt); end
  endtask

  task automatic test_back_to_back_overrun();
    do_reset(); clear_counts();
    for (int i = 1; i <= 4; i++) send_frame(4'(i), 1'b0, 1'b1, 1'b0, 0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovr_level4 got=%0d exp=4", level); end
    checks++; if (ov_cnt != 0) begin errors++; $display("FAIL ovr_early got=%0d exp=0", ov_cnt); end
    send_frame(4'h5, 1'b0, 1'b1, 1'b0, 0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovr_level got=%0d exp=4", level); end
    @(posedge clk); #1;
    checks++; if (ov_cnt != 1) begin errors++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (pvalid !== 1'b1 || pout !== 4'(i)) begin errors++;
        $display("FAIL ovr_drain%0d got=%b/%h exp=1/%h", i, pvalid, pout, 4'(i)); end
      pop_one();
    end
    checks++; if (pvalid !== 1'b0 || level !== 3'd0) begin errors++;
      $display("FAIL ovr_empty got=%b/%0d exp=0/0", pvalid, level); end
  endtask

  task automatic test_full_pop();
    do_reset(); clear_counts();
    for (int i = 1; i <= 4; i++) send_frame(4'(i), 1'b0, 1'b1, 1'b0, 0);
    send_frame(4'h7, 1'b0, 1'b1, 1'b1, 0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_ovr got=%b exp=0", overrun); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level got=%0d exp=4", level); end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] e;
      e = (i == 3) ? 4'h7 : 4'(i + 2);
      checks++; if (pout !== e) begin errors++; $display("FAIL fullpop_order%0d got=%h exp=%h", i, pout, e); end
      pop_one();
    end
    checks++; if (ov_cnt != 0) begin errors++; $display("FAIL fullpop_ovcnt got=%0d exp=0", ov_cnt); end
  endtask

  task automatic test_frame_err();
    for (int sp = 0; sp <= 2; sp += 2) begin
      do_reset(); clear_counts();
      send_frame(4'h9, 1'b0, 1'b1, 1'b0, sp);
      checks++; if (pout !== 4'h9 || level !== 3'd1) begin errors++;
        $display("FAIL ferr_good_sp%0d got=%h/%0d exp=9/1", sp, pout, level); end
      send_frame(4'h5, 1'b0, 1'b0, 1'b0, sp);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse_sp%0d got=%b exp=1", sp, frame_err); end
      checks++; if (level !== 3'd1 || pout !== 4'h9) begin errors++;
        $display("FAIL ferr_level_sp%0d got=%0d/%h exp=1/9", sp, level, pout); end
      @(posedge clk); #1;
      checks++; if (fe_cnt != 1 || pe_cnt != 0 || frame_err !== 1'b0) begin errors++;
        $display("FAIL ferr_count_sp%0d got=%0d/%0d/%b exp=1/0/0", sp, fe_cnt, pe_cnt, frame_err); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(4'hC, 1'b0, 1'b1, 1'b0, 0);
    strobe(1'b0, 0); strobe(1'b1, 0); strobe(1'b0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || level !== 3'd0 || pvalid !== 1'b0) begin errors++;
      $display("FAIL midrst_state got=%b/%0d/%b exp=0/0/0", busy, level, pvalid); end
    send_frame(4'h6, 1'b0, 1'b1, 1'b0, 0);
    checks++; if (pout !== 4'h6 || level !== 3'd1) begin errors++;
      $display("FAIL midrst_next got=%h/%0d exp=6/1", pout, level); end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    do_reset(); clear_counts();
    send_frame(4'hB, 1'b0, 1'b1, 1'b0, 0);
    checks++; if (pout !== 4'hB || level !== 3'd1 || parity_err !== 1'b0) begin errors++;
      $display("FAIL par_good got=%h/%0d/%b exp=b/1/0", pout, level, parity_err); end
    send_frame(4'hB, 1'b1, 1'b1, 1'b0, 0);
    checks++; if (parity_err !== 1'b1 || level !== 3'd1) begin errors++;
      $display("FAIL par_bad got=%b/%0d exp=1/1", parity_err, level); end
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 0);
    checks++; if (frame_err !== 1'b1 || parity_err !== 1'b0) begin errors++;
      $display("FAIL par_prio got=%b/%b exp=1/0", frame_err, parity_err); end
    @(posedge clk); #1;
    checks++; if (pe_cnt != 1 || fe_cnt != 1 || level !== 3'd1) begin errors++;
      $display("FAIL par_counts got=%0d/%0d/%0d exp=1/1/1", pe_cnt, fe_cnt, level); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back_overrun();
    test_full_pop();
    test_frame_err();
    test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Framed serial-to-parallel receiver. It accepts a bit-strobed serial stream (start bit, `n` data bits LSB first, optional parity bit, stop bit) and reassembles each frame into an `n`-bit word. Words are buffered in a small first-word-fall-through FIFO and delivered on a valid/ready parallel port. It is the receiving end of the serial links driven by the team's shift-register serializers, and it reports framing, parity and overrun errors as single-cycle pulses.

## Interface
- `n`, 4, data word width (≥2).
- `DEPTH`, 4, output FIFO depth in words; power of 2, ≥2.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sin` input 1: serial data line; idle level is 1.
- `sin_en` input 1: bit strobe; `sin` is sampled only on cycles with `sin_en`=1.
- `pout` output n: FIFO head word; valid only while `pvalid`=1.
- `pvalid` output 1: FIFO not empty.
- `pready` input 1: consumer accepts `pout` on a cycle with `pvalid && pready`.
- `level` output $clog2(DEPTH)+1: number of words held in the FIFO.
- `busy` output 1: 1 while a frame is in progress (state ≠ IDLE).
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `parity_err` output 1: one-cycle pulse on a parity mismatch; tied to 0 when parity is compiled out.
- `overrun` output 1: one-cycle pulse when a good word is dropped because the FIFO is full.

## Operation
- FSM states: IDLE, DATA, PARITY (present only with `SERIAL_RX_PARITY_EN`), STOP.
- Bits are consumed only on strobe cycles. All state is held when `sin_en`=0, and `sin` is ignored on those cycles.
- **IDLE:** `sin_en && !sin` moves to DATA and clears the bit counter. `sin_en && sin` stays in IDLE.
- **DATA:** each strobe right-shifts `sin` into the MSB of the shift register and increments the bit counter. After the n-th bit the FSM moves to PARITY if it is enabled, otherwise to STOP.
- **PARITY:** one strobe captures the parity bit, then the FSM moves to STOP.
- **STOP:** one strobe, then the FSM always returns to IDLE.
  - `sin`=0: `frame_err` pulses and the word is dropped.
  - `sin`=1 with a parity mismatch: `parity_err` pulses and the word is dropped.
  - `sin`=1 with parity good and the FIFO has room: the word is pushed.
  - `sin`=1 with parity good, FIFO full and no pop this cycle: `overrun` pulses and the word is dropped.
- `frame_err` takes priority over `parity_err`. Only one error pulse is raised per frame.
- After the stop bit the FSM enters IDLE, so a start bit is accepted on the very next strobe (back-to-back frames).
- **FIFO:** circular buffer with read/write pointers of $clog2(DEPTH)+1 bits, including a wrap bit.
  - full: pointers differ only in the wrap bit.
  - empty: pointers are equal.
  - A pop and a push in the same cycle are both performed. A push while full is accepted if a pop happens in the same cycle (no overrun).
  - `level` = wptr − rptr, modulo 2^($clog2(DEPTH)+1).
- `pout` is the registered FIFO head. While `pvalid`=0 it holds the last value.
- **Reset values:** FSM IDLE; bit counter 0; shift register 0; FIFO empty; `pout`=0; `pvalid`=0; `level`=0; `busy`=0; all error pulses 0.
- **Reset mid-frame:** the partial word is discarded and the FIFO contents are lost.

## Timing
- A word pushed at clock edge T appears on `pout` with `pvalid`=1 after edge T. T is the edge that samples the stop bit.
- Pop is registered: after the edge where `pvalid && pready`, the next word (or `pvalid`=0) is presented.
- Error pulses are asserted for exactly the one cycle following the stop-bit sampling edge.
- `busy` rises after the start-bit edge and falls after the stop-bit edge.
- Minimum frame length is n+2 strobes, or n+3 with parity. The maximum rate is `sin_en`=1 every cycle.

## Configuration
- Macro: `SERIAL_RX_PARITY_EN`.
- **Defined:** the PARITY state exists. The frame carries an even-parity bit after the data, so the XOR of the data and parity bits must be 0. A mismatch causes `parity_err` and the word is dropped.
- **Undefined:** no PARITY state, the frame is n+2 bits, and `parity_err` is constant 0.

## Test plan
All cases use n=4, DEPTH=4.
- **Single frame:** reset, then `sin_en`=1 every cycle. Send start 0, data bits 1,1,0,1, stop 1 → `pout`=4'hB and `pvalid`=1 after the stop edge; `level`=1; no error pulses.
- **Overrun:** `pready`=0, five back-to-back frames with data 1,2,3,4,5 → `level`=4 and one `overrun` pulse on the 5th frame. Then `pready`=1 → words pop in order 1,2,3,4, and `pvalid` drops after four pops.
- **Full with simultaneous pop:** FIFO full, pop on the same edge as the stop sample → word accepted, no `overrun`, `level` stays 4.
- **Framing error and sparse strobes:** a frame with stop bit 0 → `frame_err` pulses, `level` unchanged. Repeat with `sin_en` asserted every 3rd cycle and `sin` toggled on non-strobe cycles → identical results.
- **Reset mid-frame:** assert `rst` after 2 data bits → `busy`=0 and `level`=0 the next cycle. A following full frame with 4'h6 is received correctly.
- **With `SERIAL_RX_PARITY_EN`:**
  - Data 4'hB with parity 1 → accepted.
  - Data 4'hB with parity 0 → `parity_err` pulse, no push.
  - Stop 0 with a bad parity bit → only `frame_err` pulses.
